// File: rtl/pool_pkg.sv
// Shared types and elaboration helpers for the streaming pooling engine.
package pool_pkg;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } pool_state_e;

    localparam int unsigned IMG_H_W = 16;

    // Accumulator width: a full window sum of WIDTH-bit values cannot overflow.
    function automatic int unsigned acc_w(input int unsigned width, input int unsigned window);
        return width + 2 * $clog2(window);
    endfunction

    function automatic bit is_pow2(input int unsigned n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

    function automatic bit img_w_ok(input int unsigned max_w, input int unsigned window);
        return (max_w >= window) && ((max_w % window) == 0);
    endfunction

endpackage

// File: rtl/pool_engine_if.sv
// Pixel stream in and pooled stream out; the engine takes the slave modport.
interface pool_engine_if #(
    parameter int unsigned DATA_W = 2048
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/pool_lane_op.sv
// One-channel combine: signed max or signed sum at accumulator width.
module pool_lane_op
    import pool_pkg::*;
#(
    parameter int unsigned ACC_W = 36
) (
    input  pool_mode_e               mode,
    input  logic signed [ACC_W-1:0]  a,
    input  logic signed [ACC_W-1:0]  b,
    output logic signed [ACC_W-1:0]  combined
);

    always_comb begin
        combined = a;
        if (mode == POOL_AVG) begin
            combined = a + b;
        end else if (b > a) begin
            combined = b;
        end
    end

endmodule

// File: rtl/pool_engine.sv
// Streaming WINDOW x WINDOW max/average pooling over a row-major feature map,
// all channels in parallel, with a row buffer holding partial window results.
module pool_engine
    import pool_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CHANNELS  = 64,
    parameter int unsigned WINDOW    = 2,
    parameter int unsigned MAX_IMG_W = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cfg_start,
    input  logic [$clog2(MAX_IMG_W+1)-1:0]   cfg_img_w,
    input  logic [15:0]                      cfg_img_h,
    input  logic                             cfg_mode,
    output logic                             busy,
    output logic                             done,
    pool_engine_if.slave                     stream
);

    localparam int unsigned ACC_W   = acc_w(WIDTH, WINDOW);
    localparam int unsigned LOG_WIN = $clog2(WINDOW);
    localparam int unsigned SHIFT   = 2 * LOG_WIN;
    localparam int unsigned IMG_W_W = $clog2(MAX_IMG_W + 1);
    localparam int unsigned OC_N    = MAX_IMG_W / WINDOW;
    localparam int unsigned OC_W    = (OC_N > 1) ? $clog2(OC_N) : 1;

    if (!is_pow2(WINDOW)) begin : g_chk_window
        $error("pool_engine: WINDOW must be a power of two and at least 2");
    end
    if (!img_w_ok(MAX_IMG_W, WINDOW)) begin : g_chk_img_w
        $error("pool_engine: MAX_IMG_W must be a multiple of WINDOW");
    end

    pool_state_e          state;
    pool_state_e          state_next;
    pool_mode_e           mode_q;
    logic [IMG_W_W-1:0]   img_w_q;
    logic [IMG_H_W-1:0]   img_h_q;
    logic [IMG_W_W-1:0]   c_q;
    logic [IMG_H_W-1:0]   r_q;
    logic [IMG_W_W-1:0]   ow_span;
    logic [IMG_H_W-1:0]   oh_span;
    logic                 out_valid_q;
    logic                 out_last_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 start_ok;
    logic                 zero_size;
    logic                 accept;
    logic                 in_win;
    logic                 wc_first;
    logic                 wc_last;
    logic                 wr_first;
    logic                 wr_last;
    logic                 row_wrap;
    logic                 last_beat;
    logic                 last_win;
    logic                 load_out;
    logic [OC_W-1:0]      oc;

    // Pixels beyond the last whole window in either direction are consumed but dropped.
    assign ow_span   = (img_w_q >> LOG_WIN) << LOG_WIN;
    assign oh_span   = (img_h_q >> LOG_WIN) << LOG_WIN;

    assign start_ok  = (state == IDLE) && cfg_start;
    assign zero_size = (cfg_img_w == '0) || (cfg_img_h == '0);

    assign stream.in_ready = (state == RUN) && (!out_valid_q || stream.out_ready);
    assign accept    = stream.in_valid && stream.in_ready;

    assign wc_first  = (c_q[LOG_WIN-1:0] == '0);
    assign wc_last   = &c_q[LOG_WIN-1:0];
    assign wr_first  = (r_q[LOG_WIN-1:0] == '0);
    assign wr_last   = &r_q[LOG_WIN-1:0];
    assign oc        = OC_W'(c_q >> LOG_WIN);
    assign in_win    = (c_q < ow_span) && (r_q < oh_span);

    assign row_wrap  = (c_q == img_w_q - IMG_W_W'(1));
    assign last_beat = row_wrap && (r_q == img_h_q - IMG_H_W'(1));
    assign last_win  = (c_q == ow_span - IMG_W_W'(1)) && (r_q == oh_span - IMG_H_W'(1));
    assign load_out  = accept && in_win && wc_last && wr_last;

    assign stream.out_valid = out_valid_q;
    assign stream.out_last  = out_last_q;
    assign busy             = busy_q;
    assign done             = done_q;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cfg_start) begin
                    state_next = zero_size ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept && last_beat) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!out_valid_q || stream.out_ready) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mode_q      <= POOL_MAX;
            img_w_q     <= '0;
            img_h_q     <= '0;
            c_q         <= '0;
            r_q         <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state  <= state_next;
            busy_q <= (state_next == RUN) || (state_next == DRAIN);
            done_q <= (state_next == DONE);

            if (start_ok) begin
                mode_q  <= pool_mode_e'(cfg_mode);
                img_w_q <= cfg_img_w;
                img_h_q <= cfg_img_h;
                c_q     <= '0;
                r_q     <= '0;
            end else if (accept) begin
                if (row_wrap) begin
                    c_q <= '0;
                    r_q <= r_q + IMG_H_W'(1);
                end else begin
                    c_q <= c_q + IMG_W_W'(1);
                end
            end

            // A new result may replace one being accepted in the same cycle.
            if (load_out) begin
                out_valid_q <= 1'b1;
                out_last_q  <= last_win;
            end else if (stream.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        logic signed [WIDTH-1:0] px;
        logic signed [ACC_W-1:0] x;
        logic signed [ACC_W-1:0] hacc;
        logic signed [ACC_W-1:0] h_comb;
        logic signed [ACC_W-1:0] h_res;
        logic signed [ACC_W-1:0] rb_rd;
        logic signed [ACC_W-1:0] v_comb;
        logic signed [ACC_W-1:0] v_res;
        logic signed [ACC_W-1:0] avg_sh;
        logic signed [ACC_W-1:0] row_buf [OC_N];
        logic [WIDTH-1:0]        out_q;

        assign px    = stream.in_data[k*WIDTH +: WIDTH];
        assign x     = ACC_W'(px);
        assign rb_rd = row_buf[oc];

        pool_lane_op #(.ACC_W(ACC_W)) u_h_op (
            .mode     (mode_q),
            .a        (hacc),
            .b        (x),
            .combined (h_comb)
        );

        pool_lane_op #(.ACC_W(ACC_W)) u_v_op (
            .mode     (mode_q),
            .a        (h_res),
            .b        (rb_rd),
            .combined (v_comb)
        );

        // First column/row of a window overwrites, so stale state never leaks in.
        assign h_res  = wc_first ? x : h_comb;
        assign v_res  = wr_first ? h_res : v_comb;
        assign avg_sh = v_res >>> SHIFT;

        always_ff @(posedge clk) begin
            if (accept && in_win) begin
                hacc <= h_res;
                if (wc_last && !wr_last) begin
                    row_buf[oc] <= v_res;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                out_q <= '0;
            end else if (load_out) begin
                out_q <= (mode_q == POOL_AVG) ? WIDTH'(avg_sh) : WIDTH'(v_res);
            end
        end

        assign stream.out_data[k*WIDTH +: WIDTH] = out_q;
    end

endmodule

// File: doc/pool_engine.md
# pool_engine

Streaming, parametrised pooling engine: the next generation of the pool unit's max-pool datapath. It consumes a row-major feature map, one pixel per beat with all channels in parallel. For each non-overlapping WINDOW×WINDOW window it emits one pixel, either the maximum or the average, selectable at run time. It sits between the read bridge (producer) and the write bridge (consumer) under the pool controller, and replaces the fixed 4-input, 64-channel max-pool core.

## Interface
- WIDTH, 32: per-channel data width in bits, signed two's complement.
- CHANNELS, 64: channels processed in parallel per beat.
- WINDOW, 2: window edge and stride; must be a power of two, ≥2.
- MAX_IMG_W, 64: largest supported image width in pixels; must be a multiple of WINDOW.
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- cfg_start  in  1  start pulse; sampled only in IDLE.
- cfg_img_w  in  $clog2(MAX_IMG_W+1)  image width; sampled with cfg_start.
- cfg_img_h  in  16  image height; sampled with cfg_start.
- cfg_mode  in  1  0 = max, 1 = average; sampled with cfg_start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- in_valid / in_ready  in / out  1 / 1  input handshake.
- in_data  in  CHANNELS*WIDTH  pixel; channel k occupies bits [k*WIDTH +: WIDTH].
- out_valid / out_ready  out / in  1 / 1  output handshake.
- out_data  out  CHANNELS*WIDTH  pooled pixel, same packing as in_data.
- out_last  out  1  qualifies the final output beat of the image.

## Operation
- State machine:
  - IDLE → RUN on cfg_start. The start cycle latches the cfg fields and clears the row/col counters (r, c).
  - If img_w·img_h == 0, go IDLE → DONE instead.
  - RUN → DRAIN once the last input beat is accepted.
  - DRAIN → DONE when out_valid is low, or on the out_valid & out_ready cycle.
  - DONE pulses done and returns to IDLE.
- cfg_start outside IDLE is ignored.
- Per accepted beat at pixel (r, c):
  - Window column wc = c mod WINDOW; window row wr = r mod WINDOW; output column oc = c / WINDOW.
  - Beats with c ≥ OW·WINDOW or r ≥ OH·WINDOW are consumed but discarded. OW = img_w/WINDOW and OH = img_h/WINDOW, both floor.
- Horizontal accumulator (per channel): wc = 0 loads the value; other wc values combine it with the stored value.
- Row buffer: MAX_IMG_W/WINDOW entries × CHANNELS accumulators.
  - At wc = WINDOW−1, entry oc is written.
  - When wr = 0, the write is the horizontal result (overwrite, so no clearing is needed).
  - Otherwise the write combines the horizontal result with the stored entry.
  - At wr = WINDOW−1, the combined value goes to the output register instead.
- Combine rules:
  - Max mode: signed max, WIDTH bits.
  - Average mode: signed sum in ACC_W = WIDTH + 2·log2(WINDOW) bits (no overflow possible). Result = sum >>> 2·log2(WINDOW), i.e. floor, truncated to WIDTH.
- out_last = 1 on output (OH−1, OW−1).
- Reset in any state:
  - Returns to IDLE and clears counters and the output register.
  - Row-buffer contents are left stale; the overwrite rule makes them harmless.

## Timing
- Reset values: in_ready 0, out_valid 0, out_data 0, out_last 0, busy 0, done 0.
- in_ready = (state == RUN) & (!out_valid | out_ready). It is registered-state based and has no combinational path from in_valid.
- Latency: out_valid rises the cycle after the beat completing a window is accepted. Full throughput is 1 beat/cycle when out_ready stays high.
- While out_valid & !out_ready, out_data and out_last are held stable and in_ready is 0.
- Simultaneous output accept and window completion in the same cycle: the new result loads and out_valid stays high.
- done rises one cycle after the last output handshake. If no outputs exist, it rises one cycle after the last input beat.
- busy falls in the same cycle that done rises.

## Structure
- Package pool_pkg holds:
  - the mode enum (POOL_MAX, POOL_AVG) and state enum (IDLE, RUN, DRAIN, DONE);
  - the ACC_W function;
  - elaboration checks: WINDOW power of two; MAX_IMG_W mod WINDOW == 0.
- Sub-module pool_lane_op (mode, a, b → combined, ACC_W wide), instanced once per channel by a generate loop. It is shared by the horizontal and vertical combine paths.

## Test plan
Bench parameters: WIDTH=8, CHANNELS=2, WINDOW=2, MAX_IMG_W=8.
- Max mode, 4×4 image, ch0 = 4r+c, ch1 = −(4r+c):
  - ch0 outputs must be 5, 7, 13, 15.
  - ch1 outputs must be 0, −2, −8, −10.
  - out_last only on the 4th output; done one cycle later.
- Avg mode, 2×2 image:
  - ch0 = 1, 2, 3, 5 → output 2.
  - ch1 = −1, −1, −1, −2 → output −2.
  - ch1 = 127 ×4 → output 127 (no overflow).
- Backpressure: hold out_ready = 0 for 10 cycles mid-image → out_data stable, in_ready = 0, no beat lost, and the output sequence equals scenario 1.
- 5×5 max image: exactly 4 outputs; 25 input beats accepted; the dropped row 4 and column 4 do not affect results.
- Reset on beat 6 of a 4×4 image, then a fresh start → results match scenario 1, proving stale row-buffer data is overwritten.
- cfg_start asserted while busy is ignored. cfg_img_w = 0 start → no in_ready, done pulses on the 2nd cycle after start.
